// File: rtl/cell_cache_pkg.sv
// Shared types and default geometry for the cell cache / fetch scheduler slice.
package cell_cache_pkg;

   localparam int unsigned FRAME_COL_NUM_DFLT = 320;
   localparam int unsigned FRAME_ROW_NUM_DFLT = 240;
   localparam int unsigned CELL_COL_NUM_DFLT  = 8;
   localparam int unsigned CELL_ROW_NUM_DFLT  = 8;

   localparam int unsigned CELL_X_NUM = FRAME_COL_NUM_DFLT / CELL_COL_NUM_DFLT;
   localparam int unsigned CELL_Y_NUM = FRAME_ROW_NUM_DFLT / CELL_ROW_NUM_DFLT;
   localparam int unsigned CELL_TOTAL = CELL_X_NUM * CELL_Y_NUM;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      ISSUE,
      DRAIN,
      DONE
   } sched_state_e;

   typedef struct packed {
      logic top;
      logic bottom;
      logic left;
      logic right;
   } cell_edge_t;

endpackage

// File: rtl/cell_fetch_sched_if.sv
// Cell request handshake between the fetch scheduler (master) and the cell cache (slave).
interface cell_fetch_sched_if
   import cell_cache_pkg::*;
#(
   parameter int unsigned CELL_ADDR_W = 13
) ();

   logic                   cell_req_valid_o;
   logic                   cell_req_ready_i;
   logic [CELL_ADDR_W-1:0] cell_addr_o;
   cell_edge_t             cell_edge_o;

   modport master (
      output cell_req_valid_o,
      output cell_addr_o,
      output cell_edge_o,
      input  cell_req_ready_i
   );

   modport slave (
      input  cell_req_valid_o,
      input  cell_addr_o,
      input  cell_edge_o,
      output cell_req_ready_i
   );

endinterface

// File: rtl/cell_raster_cnt.sv
// Raster-order col/row/linear-address counters with registered frame-edge flags.
module cell_raster_cnt
   import cell_cache_pkg::*;
#(
   parameter int unsigned CELL_X_NUM  = 40,
   parameter int unsigned CELL_Y_NUM  = 30,
   parameter int unsigned CELL_ADDR_W = 13
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clr,
   input  logic                   adv,
   output logic [CELL_ADDR_W-1:0] addr,
   output cell_edge_t             cell_edge,
   output logic                   last
);

   localparam int unsigned COL_W = (CELL_X_NUM > 1) ? $clog2(CELL_X_NUM) : 1;
   localparam int unsigned ROW_W = (CELL_Y_NUM > 1) ? $clog2(CELL_Y_NUM) : 1;
   localparam logic [COL_W-1:0]       COL_LAST  = COL_W'(CELL_X_NUM - 1);
   localparam logic [ROW_W-1:0]       ROW_LAST  = ROW_W'(CELL_Y_NUM - 1);
   localparam logic [CELL_ADDR_W-1:0] ADDR_LAST = CELL_ADDR_W'(CELL_X_NUM * CELL_Y_NUM - 1);

   logic [COL_W-1:0] col, col_nxt;
   logic [ROW_W-1:0] row, row_nxt;
   logic             col_wrap;

   assign last = (addr == ADDR_LAST);

   always_comb begin
      col_wrap = (col == COL_LAST);
      col_nxt  = col_wrap ? '0 : col + COL_W'(1);
      row_nxt  = col_wrap ? row + ROW_W'(1) : row;
   end

   // Edge flags are computed from the next position so they stay registered alongside addr.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col       <= '0;
         row       <= '0;
         addr      <= '0;
         cell_edge <= '0;
      end else if (clr) begin
         col       <= '0;
         row       <= '0;
         addr      <= '0;
         cell_edge <= '{top: 1'b1, bottom: (ROW_LAST == '0), left: 1'b1, right: (COL_LAST == '0)};
      end else if (adv && !last) begin
         col              <= col_nxt;
         row              <= row_nxt;
         addr             <= addr + CELL_ADDR_W'(1);
         cell_edge.top    <= (row_nxt == '0);
         cell_edge.bottom <= (row_nxt == ROW_LAST);
         cell_edge.left   <= (col_nxt == '0);
         cell_edge.right  <= (col_nxt == COL_LAST);
      end
   end

endmodule

// File: rtl/cell_fetch_sched.sv
// Frame-level cell fetch scheduler: load handshake, credit-throttled raster issue, drain and done.
module cell_fetch_sched
   import cell_cache_pkg::*;
#(
   parameter int unsigned FRAME_COL_NUM      = 320,
   parameter int unsigned FRAME_ROW_NUM      = 240,
   parameter int unsigned CELL_COL_NUM       = 8,
   parameter int unsigned CELL_ROW_NUM       = 8,
   parameter int unsigned CELL_ADDR_W        = 13,
   parameter int unsigned PIPELINE_STAGE_NUM = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      frame_rd_ready_i,
   output logic                      frame_rd_valid_o,
   cell_fetch_sched_if.master        req,
   input  logic                      cell_done_i,
   output logic                      frame_busy_o,
   output logic                      frame_done_o,
   output logic                      err_o
);

   localparam int unsigned X_NUM = FRAME_COL_NUM / CELL_COL_NUM;
   localparam int unsigned Y_NUM = FRAME_ROW_NUM / CELL_ROW_NUM;
   localparam int unsigned CRD_W = $clog2(PIPELINE_STAGE_NUM + 1);
   localparam logic [CRD_W-1:0] CRD_FULL = CRD_W'(PIPELINE_STAGE_NUM);

   sched_state_e     state;
   logic [CRD_W-1:0] credits, credits_nxt;
   logic             req_valid;
   logic             fire, done_ok, last;

   assign fire = req_valid & req.cell_req_ready_i;
   // A done with a full pool only counts if an accept frees a slot in the same cycle.
   assign done_ok = cell_done_i & ((credits != CRD_FULL) | fire);
   assign req.cell_req_valid_o = req_valid;

   always_comb begin
      credits_nxt = credits;
      if (fire && !done_ok)
         credits_nxt = credits - CRD_W'(1);
      else if (!fire && done_ok)
         credits_nxt = credits + CRD_W'(1);
   end

   cell_raster_cnt #(
      .CELL_X_NUM  (X_NUM),
      .CELL_Y_NUM  (Y_NUM),
      .CELL_ADDR_W (CELL_ADDR_W)
   ) u_raster (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (state == LOAD),
      .adv       (fire),
      .addr      (req.cell_addr_o),
      .cell_edge (req.cell_edge_o),
      .last      (last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= IDLE;
         credits          <= CRD_FULL;
         req_valid        <= 1'b0;
         frame_rd_valid_o <= 1'b0;
         frame_busy_o     <= 1'b0;
         frame_done_o     <= 1'b0;
         err_o            <= 1'b0;
      end else begin
         credits          <= credits_nxt;
         frame_rd_valid_o <= 1'b0;
         frame_done_o     <= 1'b0;
         if (cell_done_i && !done_ok)
            err_o <= 1'b1;
         case (state)
            IDLE: begin
               if (frame_rd_ready_i) begin
                  state            <= LOAD;
                  frame_rd_valid_o <= 1'b1;
                  frame_busy_o     <= 1'b1;
               end
            end
            LOAD: begin
               state     <= ISSUE;
               req_valid <= (credits_nxt != '0);
            end
            ISSUE: begin
               if (fire && last) begin
                  state     <= DRAIN;
                  req_valid <= 1'b0;
               end else begin
                  req_valid <= (credits_nxt != '0);
               end
            end
            DRAIN: begin
               if (credits == CRD_FULL) begin
                  state        <= DONE;
                  frame_done_o <= 1'b1;
               end
            end
            DONE: begin
               state        <= IDLE;
               frame_busy_o <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cell_fetch_sched.sv
// Directed self-checking bench for cell_fetch_sched with a 3-cycle cell_done return model.
module tb_cell_fetch_sched;
   import cell_cache_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic frame_rd_ready_i = 1'b0;
   logic frame_rd_valid_o;
   logic cell_done_i = 1'b0;
   logic frame_busy_o, frame_done_o, err_o;

   cell_fetch_sched_if #(.CELL_ADDR_W(13)) bus ();

   cell_fetch_sched #(
      .FRAME_COL_NUM      (320),
      .FRAME_ROW_NUM      (240),
      .CELL_COL_NUM       (8),
      .CELL_ROW_NUM       (8),
      .CELL_ADDR_W        (13),
      .PIPELINE_STAGE_NUM (2)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .frame_rd_ready_i (frame_rd_ready_i),
      .frame_rd_valid_o (frame_rd_valid_o),
      .req              (bus),
      .cell_done_i      (cell_done_i),
      .frame_busy_o     (frame_busy_o),
      .frame_done_o     (frame_done_o),
      .err_o            (err_o)
   );

   always #5 clk = ~clk;

   int n_tot = 0;
   int n_bad = 0;
   int cycle = 0;
   int acc_cnt, exp_addr, done_cnt, rdv_cnt, vhi_cnt, done_cyc, last_fire_cyc;
   bit auto_done = 1'b0, man_done = 1'b0, rdy = 1'b0, frm_rdy = 1'b0;
   bit [2:0] dsr = '0;
   logic [3:0] edge_log [0:CELL_TOTAL-1];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] edge_model(input int a);
      int r, c;
      r = a / int'(CELL_X_NUM);
      c = a % int'(CELL_X_NUM);
      return {r == 0, r == int'(CELL_Y_NUM) - 1, c == 0, c == int'(CELL_X_NUM) - 1};
   endfunction

   // One clock: drive this cycle's inputs at the falling edge, then score the handshake.
   task automatic cyc();
      bit fire;
      @(negedge clk);
      cycle++;
      cell_done_i          = auto_done ? dsr[2] : man_done;
      bus.cell_req_ready_i = rdy;
      frame_rd_ready_i     = frm_rdy;
      fire = bus.cell_req_valid_o && rdy;
      dsr  = {dsr[1:0], fire};
      if (bus.cell_req_valid_o) vhi_cnt++;
      if (frame_rd_valid_o) rdv_cnt++;
      if (frame_done_o) begin
         done_cnt++;
         done_cyc = cycle;
      end
      if (fire) begin
         chk("addr", 32'(bus.cell_addr_o), 32'(exp_addr));
         chk("edge", {28'b0, bus.cell_edge_o}, {28'b0, edge_model(exp_addr)});
         if (exp_addr < int'(CELL_TOTAL)) edge_log[exp_addr] = bus.cell_edge_o;
         exp_addr++;
         acc_cnt++;
         last_fire_cyc = cycle;
      end
   endtask

   task automatic run_frame();
      int budget;
      acc_cnt = 0; exp_addr = 0; done_cnt = 0; rdv_cnt = 0;
      auto_done = 1'b1; rdy = 1'b1; dsr = '0;
      frm_rdy = 1'b1;
      cyc();
      frm_rdy = 1'b0;
      cyc();
      chk("load_pulse", 32'(frame_rd_valid_o), 1);
      chk("load_noreq", 32'(bus.cell_req_valid_o), 0);
      chk("load_busy", 32'(frame_busy_o), 1);
      cyc();
      chk("first_req", 32'(bus.cell_req_valid_o), 1);
      budget = 6000;
      while (done_cnt == 0 && budget > 0) begin
         cyc();
         budget--;
      end
      chk("frame_done_seen", 32'(done_cnt), 1);
      chk("accepts", 32'(acc_cnt), 1200);
      chk("done_latency", 32'(done_cyc - last_fire_cyc), 5);
      chk("busy_in_done", 32'(frame_busy_o), 1);
      cyc();
      chk("done_one_shot", 32'(frame_done_o), 0);
      chk("busy_after", 32'(frame_busy_o), 0);
      repeat (5) cyc();
      chk("done_pulses", 32'(done_cnt), 1);
      chk("load_pulses", 32'(rdv_cnt), 1);
      chk("edge_c0", {28'b0, edge_log[0]}, 32'b1010);
      chk("edge_c39", {28'b0, edge_log[39]}, 32'b1001);
      chk("edge_c1160", {28'b0, edge_log[1160]}, 32'b0110);
      chk("edge_c1199", {28'b0, edge_log[1199]}, 32'b0101);
      chk("err_clean", 32'(err_o), 0);
   endtask

   initial begin
      int acc_before, budget;
      acc_cnt = 0; exp_addr = 0; done_cnt = 0; rdv_cnt = 0; vhi_cnt = 0;
      done_cyc = 0; last_fire_cyc = 0;
      bus.cell_req_ready_i = 1'b0;

      // reset and idle
      repeat (3) cyc();
      chk("rst_rdv", 32'(frame_rd_valid_o), 0);
      chk("rst_valid", 32'(bus.cell_req_valid_o), 0);
      chk("rst_addr", 32'(bus.cell_addr_o), 0);
      chk("rst_edge", {28'b0, bus.cell_edge_o}, 0);
      chk("rst_busy", 32'(frame_busy_o), 0);
      chk("rst_done", 32'(frame_done_o), 0);
      chk("rst_err", 32'(err_o), 0);
      rst_n = 1'b1;
      vhi_cnt = 0;
      repeat (20) cyc();
      chk("idle_noreq", 32'(vhi_cnt), 0);
      chk("idle_busy", 32'(frame_busy_o), 0);

      run_frame();

      // credit stall
      auto_done = 1'b0; man_done = 1'b0; rdy = 1'b1;
      acc_cnt = 0; exp_addr = 0; dsr = '0;
      frm_rdy = 1'b1;
      cyc();
      frm_rdy = 1'b0;
      repeat (8) cyc();
      chk("stall_acc", 32'(acc_cnt), 2);
      chk("stall_valid", 32'(bus.cell_req_valid_o), 0);
      chk("stall_addr", 32'(bus.cell_addr_o), 2);
      man_done = 1'b1; cyc(); man_done = 1'b0;
      repeat (6) cyc();
      chk("stall_one_more", 32'(acc_cnt), 3);
      chk("stall_valid2", 32'(bus.cell_req_valid_o), 0);
      chk("stall_addr2", 32'(bus.cell_addr_o), 3);

      // backpressure on addr 3
      rdy = 1'b0;
      man_done = 1'b1; cyc(); man_done = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("bp_valid", 32'(bus.cell_req_valid_o), 1);
         chk("bp_addr", 32'(bus.cell_addr_o), 3);
         chk("bp_edge", {28'b0, bus.cell_edge_o}, 32'b1000);
      end
      rdy = 1'b1;
      cyc();
      chk("bp_acc", 32'(acc_cnt), 4);

      // simultaneous accept and done
      rdy = 1'b0;
      man_done = 1'b1; cyc(); man_done = 1'b0;
      cyc();
      rdy = 1'b1; man_done = 1'b1;
      cyc();
      rdy = 1'b0; man_done = 1'b0;
      cyc();
      chk("sim_valid", 32'(bus.cell_req_valid_o), 1);
      chk("sim_addr", 32'(bus.cell_addr_o), 5);
      chk("sim_err", 32'(err_o), 0);
      man_done = 1'b1; cyc(); man_done = 1'b0;
      cyc();
      chk("full_no_err", 32'(err_o), 0);
      man_done = 1'b1; cyc(); man_done = 1'b0;
      cyc();
      chk("overflow_err", 32'(err_o), 1);
      acc_before = acc_cnt;
      rdy = 1'b1;
      repeat (6) cyc();
      chk("credit_cap", 32'(acc_cnt - acc_before), 2);
      chk("err_sticky", 32'(err_o), 1);

      // refill credits, then run to address 600 and reset mid-frame
      rdy = 1'b0;
      man_done = 1'b1; cyc(); cyc(); man_done = 1'b0;
      auto_done = 1'b1; dsr = '0; rdy = 1'b1;
      budget = 4000;
      while (!(bus.cell_req_valid_o && bus.cell_addr_o == 13'd600) && budget > 0) begin
         cyc();
         budget--;
      end
      chk("reached_600", 32'(bus.cell_addr_o), 600);
      rst_n = 1'b0;
      auto_done = 1'b0; man_done = 1'b0; rdy = 1'b0; dsr = '0;
      cell_done_i = 1'b0;
      bus.cell_req_ready_i = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(bus.cell_req_valid_o), 0);
      chk("mid_rst_addr", 32'(bus.cell_addr_o), 0);
      chk("mid_rst_edge", {28'b0, bus.cell_edge_o}, 0);
      chk("mid_rst_busy", 32'(frame_busy_o), 0);
      chk("mid_rst_err", 32'(err_o), 0);
      chk("mid_rst_rdv", 32'(frame_rd_valid_o), 0);
      chk("mid_rst_done", 32'(frame_done_o), 0);
      repeat (3) cyc();
      rst_n = 1'b1;
      repeat (2) cyc();

      run_frame();

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule

// File: doc/cell_fetch_sched.md
# cell_fetch_sched

Cell fetch scheduler sitting between the frame FIFO, the cell cache and the HOG pipeline. Once the frame FIFO holds a complete frame, it commands the cell cache to capture it, then walks every 8x8 cell in raster order, issuing one cell address per handshake. It throttles issue with a credit counter sized to the cell/HOG pipeline depth and signals frame completion once every issued cell has been delivered.

## Interface
Parameters:
- FRAME_COL_NUM, 320, frame width in pixels
- FRAME_ROW_NUM, 240, frame height in pixels
- CELL_COL_NUM, 8, cell width in pixels
- CELL_ROW_NUM, 8, cell height in pixels
- CELL_ADDR_W, 13, linear cell address width
- PIPELINE_STAGE_NUM, 2, max cells in flight (credit pool size)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- frame_rd_ready_i  in  1  frame FIFO holds a complete frame
- frame_rd_valid_o  out  1  one-cycle pulse: cache captures frame, FIFO pops it
- cell_req_valid_o  out  1  cell request valid
- cell_req_ready_i  in  1  cache accepts request
- cell_addr_o  out  CELL_ADDR_W  linear cell index, row*CELL_X_NUM+col
- cell_edge_o  out  4  {top, bottom, left, right} frame-edge flags for boundary expansion
- cell_done_i  in  1  one-cycle pulse: one cell delivered to HOG
- frame_busy_o  out  1  high from LOAD through DONE
- frame_done_o  out  1  one-cycle pulse: all cells of the frame delivered
- err_o  out  1  sticky: cell_done_i received with no cell in flight

## Operation
- Derived: CELL_X_NUM = FRAME_COL_NUM/CELL_COL_NUM (40), CELL_Y_NUM = FRAME_ROW_NUM/CELL_ROW_NUM (30), CELL_TOTAL = 1200.
- States: IDLE, LOAD, ISSUE, DRAIN, DONE.
- IDLE: when frame_rd_ready_i=1, go to LOAD.
- LOAD: frame_rd_valid_o=1 for exactly this cycle; clear col/row/addr; go to ISSUE.
- ISSUE: cell_req_valid_o=1 while credits>0. On valid&&ready: credits--, advance col (wrap at CELL_X_NUM-1 to 0, row++), addr++. When the accepted cell is CELL_TOTAL-1, go to DRAIN.
- DRAIN: no requests; wait for credits==PIPELINE_STAGE_NUM, then go to DONE.
- DONE: frame_done_o=1 for one cycle; go to IDLE.
- Credits: cell_done_i increments, an accepted request decrements; both in the same cycle leave the count unchanged. A cell_done_i arriving when credits==PIPELINE_STAGE_NUM (and no simultaneous accept) is dropped and sets err_o.
- Addressing uses counters only, no multiplier. cell_edge_o: top=(row==0), bottom=(row==CELL_Y_NUM-1), left=(col==0), right=(col==CELL_X_NUM-1).
- Valid rule: once cell_req_valid_o is asserted, it and cell_addr_o/cell_edge_o hold until accepted. A credit can only drop through a handshake, so this holds by construction.
- frame_rd_ready_i is ignored outside IDLE.

## Timing
- Reset: state=IDLE, credits=PIPELINE_STAGE_NUM, all outputs 0, addr/row/col 0, err_o 0.
- All outputs are registered.
- Latency:
  - frame_rd_ready_i high in IDLE at cycle n: LOAD at n+1 (frame_rd_valid_o high), first cell_req_valid_o at n+2.
  - Zero-wait ready: one cell per cycle until credits run out.
- Final accept at cycle m with credits already full after the final done pulse at cycle k: frame_done_o at max(m,k)+2. The DRAIN check is taken the cycle after credits refill, then DONE.
- Back-to-back frames: IDLE samples frame_rd_ready_i in the cycle after DONE.
- Reset mid-frame returns to IDLE immediately, drops in-flight credits and clears err_o. The cache and FIFO must be reset in the same domain.

## Structure
- Shared package cell_cache_pkg:
  - derived constants CELL_X_NUM, CELL_Y_NUM, CELL_TOTAL
  - state enum sched_state_e
  - packed struct cell_edge_t {top, bottom, left, right}
- Sub-module cell_raster_cnt: col/row/addr counters with clear, advance and last-cell flag, plus edge-flag generation.
- The FSM and credit counter stay in the top module.

## Test plan
- Reset then idle: all outputs 0 and credits=2. No cell_req_valid_o for 20 cycles with frame_rd_ready_i=0.
- Full frame, ready tied 1, cell_done_i returned 3 cycles after each accept:
  - exactly 1200 requests with addresses 0..1199
  - cell 0 edges {1,0,1,0}, cell 39 {1,0,0,1}, cell 1160 {0,1,1,0}, cell 1199 {0,1,0,1}
  - one frame_done_o pulse
- Credit stall: withhold cell_done_i after 2 accepts. cell_req_valid_o drops and addr holds at 2; after one done pulse, exactly one more request issues.
- Backpressure: ready low for 5 cycles while valid is high. Valid, address and edges stay stable and no address is skipped.
- Simultaneous accept and cell_done_i in one cycle: credits unchanged. A done pulse with credits full sets err_o, which stays set until reset.
- Reset asserted at address 600: outputs return to reset values. The next frame restarts at address 0 with a fresh frame_rd_valid_o pulse.
